// File: rtl/display_scheduler.sv
// display_scheduler
//   Decides when the seven-segment shift chain is reloaded and with which
//   frame. Two candidate frames (page 0 / page 1) are chosen by automatic
//   rotation every PAGE_SECONDS updates or by a user toggle. Each reload is
//   a one-cycle start pulse plus a data word held stable until the next
//   reload. Requests arriving while one is already pending are collapsed
//   and counted.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   update_i     pulse: digit values changed, reload needed
//   toggle_i     pulse: switch to the other page now
//   auto_i       level: enable page rotation
//   frame0_i     page 0 frame (time + date)
//   frame1_i     page 1 frame (time + year)
//   busy_i       shift_reg transfer in progress
//   start_o      one-cycle start pulse to shift_reg
//   data_o       registered frame to shift_reg
//   page_o       current page
//   drop_count_o saturating count of collapsed / timed-out requests
module display_scheduler #(
  parameter int unsigned WIDTH        = 84,
  parameter int unsigned PAGE_SECONDS = 5,
  parameter int unsigned ACK_TIMEOUT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_i,
  input  logic             toggle_i,
  input  logic             auto_i,
  input  logic [WIDTH-1:0] frame0_i,
  input  logic [WIDTH-1:0] frame1_i,
  input  logic             busy_i,
  output logic             start_o,
  output logic [WIDTH-1:0] data_o,
  output logic             page_o,
  output logic [3:0]       drop_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(PAGE_SECONDS - 1);
  localparam logic [3:0] ACK_LAST   = 4'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             page_q, page_d;
  logic [3:0]       drop_q, drop_d;
  logic [3:0]       ack_cnt_q, ack_cnt_d;
  logic             start_q;
  logic [WIDTH-1:0] data_q;

  logic expire, flip, timeout, load, set_evt, drop_inc;

  // Page rotation / toggle. A toggle coinciding with dwell expiry is a
  // single flip, not two.
  always_comb begin
    expire  = auto_i && update_i && (dwell_q == DWELL_LAST);
    flip    = toggle_i || expire;
    page_d  = page_q ^ flip;
    dwell_d = dwell_q;
    if (flip || !auto_i) begin
      dwell_d = '0;
    end else if (update_i) begin
      dwell_d = dwell_q + 8'd1;
    end
  end

  // Transfer FSM.
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    timeout   = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (busy_i) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending flag and drop counter. A set event in the same cycle as the
  // issue keeps the flag set so the newer request is not lost. Coincident
  // set events (e.g. update plus the flip it causes) count as one request.
  always_comb begin
    set_evt   = update_i || flip || timeout;
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b0;
    end
    if (set_evt) begin
      pending_d = 1'b1;
    end
    drop_inc = timeout || (set_evt && pending_q);
    drop_d   = drop_q;
    if (drop_inc && (drop_q != 4'hF)) begin
      drop_d = drop_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      dwell_q   <= '0;
      page_q    <= 1'b0;
      drop_q    <= '0;
      ack_cnt_q <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dwell_q   <= dwell_d;
      page_q    <= page_d;
      drop_q    <= drop_d;
      ack_cnt_q <= ack_cnt_d;
      start_q   <= (state_d == ISSUE);
      if (load) begin
        // Frame follows the page as updated in this same cycle.
        data_q <= page_d ? frame1_i : frame0_i;
      end
    end
  end

  assign start_o      = start_q;
  assign data_o       = data_q;
  assign page_o       = page_q;
  assign drop_count_o = drop_q;

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Controller between the seven-segment frame builders and `shift_reg` that decides when, and with which frame, the display chain is reloaded. Two candidate frames (page 0: time + date, page 1: time + year) are selected by automatic rotation or a user toggle. Each reload is issued to `shift_reg` with a start pulse and a held-stable data word. Update requests that arrive mid-transfer are collapsed into one pending request and counted.

## Interface

Parameters:
- WIDTH, 84, frame width in bits (7 × 12 digits).
- PAGE_SECONDS, 5, number of `update_i` pulses a page is shown before auto-rotation; range 1–255.
- ACK_TIMEOUT, 4, maximum number of cycles from `start_o` to `busy_i` rising; range 1–15.

Ports:
- clk_i  input  1  system clock; one clock domain.
- rst_i  input  1  synchronous reset, active-high.
- update_i  input  1  single-cycle pulse; the digit values have changed and a reload is needed.
- toggle_i  input  1  single-cycle pulse; advance to the other page now.
- auto_i  input  1  level; 1 enables page rotation every PAGE_SECONDS updates.
- frame0_i  input  WIDTH  page 0 frame.
- frame1_i  input  WIDTH  page 1 frame.
- busy_i  input  1  `shift_reg` is transferring (high from accept to latch).
- start_o  output  1  single-cycle pulse to `shift_reg.start_i`.
- data_o  output  WIDTH  frame for `shift_reg.data_i`, registered.
- page_o  output  1  current page.
- drop_count_o  output  4  saturating count of collapsed or timed-out requests.

## Operation

- Reset values: state IDLE, `start_o`=0, `data_o`=0, `page_o`=0, `drop_count_o`=0, pending=0, dwell=0.
- Pending flag (registered):
  - Set by `update_i`, by any page change, or by an ACK timeout.
  - Cleared on the IDLE→ISSUE transition.
  - If a set event arrives while pending is already 1, pending stays 1 and `drop_count_o` increments.
  - `drop_count_o` saturates at 15 and clears only on reset.
- Page logic:
  - When `auto_i`=1, dwell counts `update_i` pulses.
  - When dwell reaches PAGE_SECONDS−1 and another `update_i` arrives, the page flips and dwell returns to 0.
  - `toggle_i` flips the page and zeroes dwell, regardless of `auto_i`.
  - If `toggle_i` and the dwell expiry occur in the same cycle, the page flips once.
  - When `auto_i`=0, dwell holds at 0.
- FSM states:
  - IDLE: when pending=1, load `data_o` from the frame selected by the page value as updated this cycle, then go to ISSUE.
  - ISSUE: `start_o`=1 for exactly this cycle, then go to WAIT_ACK.
  - WAIT_ACK: on `busy_i`=1, go to WAIT_DONE. If ACK_TIMEOUT cycles pass without `busy_i`, go to IDLE, set pending, and increment `drop_count_o`.
  - WAIT_DONE: on `busy_i`=0, go to IDLE.
- `data_o` changes only on the IDLE→ISSUE transition. It is held constant through ISSUE, WAIT_ACK and WAIT_DONE.

## Timing

- `update_i` high at cycle t with FSM in IDLE and pending=0:
  - pending=1 at t+1;
  - `data_o` valid at t+2;
  - `start_o` high at t+2.
  - Latency is 2 cycles.
- Back-to-back reloads: a request pending during WAIT_DONE issues `start_o` 2 cycles after `busy_i` falls (IDLE at +1, ISSUE at +2).
- `busy_i` already high in the ISSUE cycle is ignored. Acknowledge is sampled only in WAIT_ACK, starting 1 cycle after `start_o`.
- Timeout: with no `busy_i`, the FSM is back in IDLE ACK_TIMEOUT+1 cycles after `start_o`. The retry `start_o` follows 1 cycle later.
- `rst_i` mid-transfer returns all state to reset values on the next edge. No `start_o` is emitted until a new request arrives.
- `page_o` updates the cycle after the triggering pulse, independent of FSM state.

## Test plan

- Reset: hold `rst_i` for 2 cycles → `start_o`=0, `data_o`=0, `page_o`=0, `drop_count_o`=0. No `start_o` for 20 cycles without a request.
- Single update: frame0=A, `update_i` at t, model `busy_i` high from t+4 to t+10 → `start_o` only at t+2, `data_o`=A from t+2 through t+10, FSM idle at t+11.
- Collapse: issue 3 `update_i` pulses during WAIT_DONE → exactly one further `start_o`, 2 cycles after `busy_i` falls; `drop_count_o`=2.
- Rotation: `auto_i`=1, PAGE_SECONDS=5, 5 updates spaced 200 cycles apart → `page_o` flips after the 5th. The 5th reload carries frame1; reloads 1–4 carry frame0.
- Toggle and expiry in the same cycle: `toggle_i` coincident with the 5th update → `page_o` flips once (0→1) and one reload is issued.
- ACK timeout: `busy_i` tied 0 → `start_o` repeats every ACK_TIMEOUT+2=6 cycles; `drop_count_o` saturates at 15 and does not wrap.
